// File: rtl/alu_pkg.sv
// alu_pkg: types shared by the ALU and its command front-end.
//   alu_op_e   2-bit opcode (add, sub, mul, div)
//   alu_cmd_t  packed command {op, a, b} at the default ALU width
//   ALU_WIDTH  default operand/result width
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef struct packed {
    alu_op_e                op;
    logic [ALU_WIDTH-1:0]   a;
    logic [ALU_WIDTH-1:0]   b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with a combinational head read.
//   clk, rst_n   clock, asynchronous active-low reset
//   push, push_data   write request (ignored when full)
//   pop          read request (ignored when empty)
//   head         oldest entry, valid while !empty
//   count        occupancy 0..DEPTH
//   full, empty  decoded from the registered count
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned  AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffered command front-end for the combinational ALU.
//   cmd_valid/cmd_ready, cmd_op/cmd_a/cmd_b   command input handshake
//   alu_a/alu_b/alu_sel -> ALU, alu_out <- ALU (head of queue, 0 when empty)
//   res_valid/res_ready, res_data/res_op/res_err  registered result handshake
//   fifo_count                                 queued command count
// Optional macro DIV_ZERO_CHECK_EN: a divide by zero yields res_err=1 and
// res_data all-ones instead of the ALU's own output.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [1:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [1:0]               res_op,
  output logic                     res_err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned DW = 2 + 2 * WIDTH;

  logic [DW-1:0]    head;
  logic             fifo_full, fifo_empty;
  logic             push, issue;
  alu_op_e          head_op;
  logic [WIDTH-1:0] head_a, head_b;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q,  res_data_d;
  logic [1:0]       res_op_q,    res_op_d;
  logic             res_err_q,   res_err_d;

  assign head_op = alu_op_e'(head[DW-1 -: 2]);
  assign head_a  = head[2*WIDTH-1 -: WIDTH];
  assign head_b  = head[WIDTH-1:0];

  // cmd_ready depends only on the registered count: no full-and-popping bypass
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign issue     = !fifo_empty && (!res_valid_q || res_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({cmd_op, cmd_a, cmd_b}),
    .pop       (issue),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!fifo_empty) begin
      alu_a   = head_a;
      alu_b   = head_b;
      alu_sel = head_op;
    end
  end

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_op_d    = head_op;
      res_data_d  = alu_out;
      res_err_d   = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      if (head_op == OP_DIV && head_b == '0) begin
        res_data_d = '1;
        res_err_d  = 1'b1;
      end
`endif
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: bench for alu_cmd_sequencer (DEPTH=4, WIDTH=8).
// Plays the role of the combinational ALU, keeps a queue-based model of the
// sequencer checked every cycle, and pins the model with literal results.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_a = '0, cmd_b = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [1:0]       alu_sel;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_op;
  logic             res_err;
  logic [2:0]       fifo_count;

  int total = 0;
  int bad   = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_out(alu_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
    .res_err(res_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference ALU; divide by zero returns 0.
  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int unsigned r;
    case (op)
      2'd0: r = (int'(a) + int'(b)) % 256;
      2'd1: r = (int'(a) - int'(b) + 256) % 256;
      2'd2: r = (int'(a) * int'(b)) % 256;
      default: r = (b == 0) ? 0 : int'(a) / int'(b);
    endcase
    return r[7:0];
  endfunction

  always_comb alu_out = alu_f(alu_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model and per-cycle compare ----------------
  alu_cmd_t   mq[$];
  logic       mrv;
  logic [7:0] md;
  logic [1:0] mo;
  logic       me;
  logic [7:0] log_data[$];
  int         log_cyc[$];
  int         cyc = 0;

  always @(negedge clk) begin
    logic pop_m, push_m;
    alu_cmd_t c;
    cyc++;
    if (!rst_n) begin
      mq.delete();
      mrv = 1'b0; md = '0; mo = '0; me = 1'b0;
    end
    chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
    chk("fifo_count", fifo_count, mq.size());
    chk("alu_a", alu_a, mq.size() > 0 ? mq[0].a : 8'd0);
    chk("alu_b", alu_b, mq.size() > 0 ? mq[0].b : 8'd0);
    chk("alu_sel", alu_sel, mq.size() > 0 ? mq[0].op : 2'd0);
    chk("res_valid", res_valid, mrv);
    chk("res_data", res_data, md);
    chk("res_op", res_op, mo);
    chk("res_err", res_err, me);
    if (rst_n) begin
      if (mrv && res_ready) begin
        log_data.push_back(md);
        log_cyc.push_back(cyc);
      end
      pop_m  = (mq.size() > 0) && (!mrv || res_ready);
      push_m = cmd_valid && (mq.size() < DEPTH);
      if (pop_m) begin
        c   = mq.pop_front();
        mrv = 1'b1;
        mo  = c.op;
        md  = alu_f(c.op, c.a, c.b);
        me  = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
        if (c.op == OP_DIV && c.b == 0) begin
          md = 8'hFF;
          me = 1'b1;
        end
`endif
      end else if (mrv && res_ready) begin
        mrv = 1'b0;
      end
      if (push_m) mq.push_back('{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b});
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_one(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((fifo_count != 0 || res_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (fifo_count != 0 || res_valid) begin
      total++; bad++;
      $display("FAIL %s: drain timeout count=%0d valid=%0b", name, fifo_count, res_valid);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int mark, acc;
    logic [7:0] exp_bp [6];
    exp_bp[0] = 8'd1; exp_bp[1] = 8'd5; exp_bp[2] = 8'd9;
    exp_bp[3] = 8'd13; exp_bp[4] = 8'd17; exp_bp[5] = 8'd42;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_valid", res_valid, 0);
    @(posedge clk); #1;

    // single add: 200+100 wraps to 44, visible two cycles after push
    res_ready = 1'b1;
    push_one(2'd0, 8'd200, 8'd100);
    @(negedge clk);
    chk("single_head_a", alu_a, 200);
    chk("single_not_yet", res_valid, 0);
    @(negedge clk);
    chk("single_valid", res_valid, 1);
    chk("single_data", res_data, 44);
    chk("single_op", res_op, 0);
    chk("single_err", res_err, 0);
    wait_drain("single");

    // streaming, one result per cycle
    mark = log_data.size();
    push_one(2'd1, 8'd5, 8'd7);
    push_one(2'd2, 8'd16, 8'd17);
    push_one(2'd3, 8'd100, 8'd7);
    wait_drain("stream");
    chk("stream_n", log_data.size() - mark, 3);
    if (log_data.size() >= mark + 3) begin
      chk("stream_sub", log_data[mark], 8'hFE);
      chk("stream_mul", log_data[mark+1], 8'h10);
      chk("stream_div", log_data[mark+2], 8'd14);
      chk("stream_b2b1", log_cyc[mark+1] - log_cyc[mark], 1);
      chk("stream_b2b2", log_cyc[mark+2] - log_cyc[mark+1], 1);
    end

    // backpressure: 6 offered, 5 accepted
    mark = log_data.size();
    res_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 8'(i * 3); cmd_b = 8'(i + 1);
      @(negedge clk);
      if (cmd_ready) acc++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc, 5);
    @(negedge clk);
    chk("bp_full_ready", cmd_ready, 0);
    chk("bp_full_count", fifo_count, 4);
    chk("bp_held", res_valid, 1);
    @(posedge clk); #1;

    // full with simultaneous pop: no push this cycle, push next cycle
    res_ready = 1'b1;
    cmd_op = 2'd1; cmd_a = 8'd50; cmd_b = 8'd8;
    @(negedge clk);
    chk("fullpop_ready0", cmd_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fullpop_count", fifo_count, 3);
    chk("fullpop_ready1", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_drain("bp");
    chk("bp_n", log_data.size() - mark, 6);
    if (log_data.size() >= mark + 6)
      for (int i = 0; i < 6; i++) chk($sformatf("bp_order%0d", i), log_data[mark+i], exp_bp[i]);

    // divide by zero
    res_ready = 1'b1;
    push_one(2'd3, 8'd9, 8'd0);
    @(negedge clk);
    @(negedge clk);
    chk("dz_valid", res_valid, 1);
    chk("dz_op", res_op, 3);
`ifdef DIV_ZERO_CHECK_EN
    chk("dz_data", res_data, 8'hFF);
    chk("dz_err", res_err, 1);
`else
    chk("dz_data", res_data, 8'h00);
    chk("dz_err", res_err, 0);
`endif
    wait_drain("dz");

    // asynchronous reset mid-stream with 3 queued
    res_ready = 1'b0;
    push_one(2'd0, 8'd1, 8'd2);
    push_one(2'd2, 8'd3, 8'd4);
    push_one(2'd1, 8'd9, 8'd4);
    push_one(2'd0, 8'd7, 8'd7);
    chk("pre_rst_count", fifo_count, 3);
    chk("pre_rst_valid", res_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", fifo_count, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_data", res_data, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_alu_a", alu_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Buffered command front-end that sits directly upstream of the combinational 8-bit ALU. It accepts {opcode, A, B} commands over a valid/ready handshake and queues them in a small FIFO. It presents the FIFO head to the ALU's A/B/ALU_Sel inputs, captures ALU_Out into a registered result stage, and hands results downstream over a second valid/ready handshake. It provides one-result-per-cycle throughput with full backpressure in both directions.

## Interface
- DEPTH, 4, command FIFO depth; power of two, ≥2
- WIDTH, 8, operand/result width; must match the ALU
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- alu_a  output  WIDTH  to ALU A
- alu_b  output  WIDTH  to ALU B
- alu_sel  output  2  to ALU_Sel
- alu_out  input  WIDTH  from ALU_Out
- res_valid  output  1  result present
- res_ready  input  1  downstream accepts result
- res_data  output  WIDTH  result value
- res_op  output  2  opcode that produced res_data
- res_err  output  1  divide-by-zero flag
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: occurs when cmd_valid && cmd_ready. cmd_ready = (fifo_count < DEPTH), decoded from registered count only. There is no same-cycle bypass: when the FIFO is full, cmd_ready stays 0 even if a pop occurs that cycle.
- ALU drive: when the FIFO is non-empty, alu_a/alu_b/alu_sel = head entry (combinational from storage). When empty, all three are driven 0.
- Issue/pop: fires when FIFO non-empty && (!res_valid || res_ready).
  - On fire, the result register loads res_data←alu_out, res_op←head op, res_err per Configuration, and res_valid←1.
  - The head pointer advances on the same edge.
- Drain: when res_valid && res_ready and no issue fires, res_valid←0. res_data, res_op and res_err hold their last values.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Arithmetic is entirely the ALU's. The sequencer passes alu_out unmodified:
  - add/sub wrap mod 2^WIDTH
  - mul is truncated to the low WIDTH bits
  - div is unsigned floor
- Result stability: res_data, res_op and res_err remain stable while res_valid && !res_ready.
- Reset (any time, including mid-stream):
  - pointers and fifo_count go to 0, and queued commands are discarded
  - res_valid=0, res_data=0, res_op=0, res_err=0, cmd_ready=1 (combinational from count), alu_* = 0

## Timing
- Latency: a command accepted at edge N becomes head in cycle N+1 (if the FIFO was empty). It is captured at edge N+1, so res_valid is high in cycle N+2. Minimum latency is 2 cycles.
- Throughput: 1 result/cycle sustained with res_ready held high.
- res_ready low: at most DEPTH commands queue, plus 1 held in the result register.
- Combinational paths:
  - FIFO head → ALU → result register is the critical path.
  - res_ready → pop is combinational.
  - cmd_valid has no combinational path to cmd_ready.

## Configuration
- DIV_ZERO_CHECK_EN defined: when the head op is 11 and the head B is 0, the issue captures res_err=1 and res_data={WIDTH{1'b1}}, ignoring alu_out. All other issues capture res_err=0.
- DIV_ZERO_CHECK_EN undefined: res_err is tied 0 and res_data is always alu_out, so the ALU's divide-by-zero result passes through.

## Structure
- Package alu_pkg: 2-bit opcode enum (OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3), the command struct {op, a, b}, and a default WIDTH constant. Shared with the ALU's users.
- Sub-module alu_cmd_fifo: parameterised synchronous FIFO with push/pop/count/full/empty and a combinational head read. The sequencer owns the issue logic and the result register.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 entries queued → fifo_count=0, res_valid=0, res_data=0, cmd_ready=1 immediately (asynchronous).
- Single command: push add A=8'd200, B=8'd100 in cycle 0 → res_valid in cycle 2, res_data=8'd44, res_op=00, res_err=0.
- Streaming: push sub 5-7, mul 16×17, div 100/7 back-to-back with res_ready=1 → results 8'hFE, 8'h10, 8'd14 on consecutive cycles.
- Backpressure: res_ready=0, push 6 commands with DEPTH=4 → 5 accepted (4 queued, 1 in the result register), cmd_ready=0, fifo_count=4. Releasing res_ready drains all in order with no loss or duplication.
- Full with simultaneous pop: FIFO full and res_ready=1 while cmd_valid=1 → no push that cycle, and a push is accepted the following cycle.
- Divide by zero: div A=8'd9, B=0 → with DIV_ZERO_CHECK_EN, res_err=1 and res_data=8'hFF. Without the macro, res_err=0 and res_data equals the ALU output.
